mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Parametrised load/store engine between the multi-cycle CPU datapath and the MIO bus.
//  Adds the MIO_ready wait-state handshake and byte/half/word(/dword) lane steering.
//  Adds sign/zero extension, alignment checking and a bus timeout.
//  The control FSM holds its MEM state while busy=1 and resumes on done/err pulses.
// PARAMETERS
//  DATA_W   32  bus/data width; legal values 32 or 64
//  ADDR_W   32  address width
//  TIMEOUT  15  max wait cycles for mem_ready per attempt; 0 = wait forever
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         asynchronous, active-low reset
//  req          in   1         access request; sampled only in IDLE
//  we           in   1         1=store, 0=load
//  size         in   2         00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
//  sign_ext     in   1         load: 1 sign-extend, 0 zero-extend
//  addr         in   ADDR_W    byte address
//  wdata        in   DATA_W    store data, right-justified
//  rdata        out  DATA_W    extended load result; held until next load completes
//  busy         out  1         high from accept cycle+1 until done/err cycle inclusive
//  done         out  1         1-cycle pulse: access completed
//  err_align    out  1         1-cycle pulse: misaligned request, no bus cycle issued
//  err_timeout  out  1         1-cycle pulse: mem_ready never arrived
//  mem_req      out  1         bus strobe (CPU_MIO)
//  mem_w        out  1         bus write enable
//  mem_addr     out  ADDR_W    addr with low log2(DATA_W/8) bits cleared
//  mem_be       out  DATA_W/8  byte enables
//  mem_wdata    out  DATA_W    lane-shifted store data
//  mem_rdata    in   DATA_W    bus read data
//  mem_ready    in   1         bus completion (MIO_ready)
// BEHAVIOUR
//  Reset: all outputs 0, rdata=0, FSM=IDLE, counters 0; async, also mid-access (mem_req drops at once).
//  States: IDLE, BUS, DONE, ERR.
//  - IDLE, req=1: latch we/size/sign_ext/addr/wdata; misaligned -> ERR, else -> BUS.
//  - IDLE, req=0: stay. req while busy ignored; inputs after acceptance ignored.
//  - BUS: mem_req=1, mem_w=we, mem_addr/mem_be/mem_wdata driven from latched values.
//    - mem_ready=1 sampled -> capture rdata (loads only) -> DONE.
//  - Timeout counter counts BUS cycles with mem_ready=0. Reaching TIMEOUT -> ERR.
//    - mem_ready on the same edge as reaching TIMEOUT: ready wins.
//  - DONE: done=1 for one cycle -> IDLE. ERR: err_* pulse one cycle -> IDLE.
//  - Min latency: req edge -> BUS edge -> (ready) DONE; done visible 2 cycles after accept.
//  Alignment: half needs addr[0]=0, word addr[1:0]=0, dword addr[2:0]=0.
//    - size=11 with DATA_W=32: always err_align.
//  Lanes: lane = addr mod (DATA_W/8).
//    - mem_be = size mask << lane; mem_wdata = wdata << 8*lane; little-endian.
//  Loads: rdata = extend((mem_rdata >> 8*lane) masked to size); full-width loads have no extension.
//  mem_be=0 and mem_wdata=0 outside BUS.
// CONFIGURATION
//  MAU_RETRY_EN defined:
//    - First timeout drops mem_req for one cycle (state RETRY).
//    - Re-enters BUS with counter cleared. Second timeout -> ERR.
//    - busy stays high throughout.
//  MAU_RETRY_EN undefined: first timeout -> ERR; no RETRY state exists.
// TESTING
//  1. Word load addr=0x10, mem_rdata=0xDEADBEEF, ready 3 cycles late
//     -> mem_be=1111, rdata=0xDEADBEEF, done 1 cycle.
//  2. Byte load sign_ext=1, addr=0x13, mem_rdata=0x80xxxxxx -> rdata=0xFFFFFF80.
//     - sign_ext=0 -> rdata=0x00000080.
//  3. Half store addr=0x22, wdata=0x0000ABCD
//     -> mem_be=1100, mem_wdata=0xABCD0000, mem_addr=0x20, mem_w=1.
//  4. Word req addr=0x21 -> err_align pulse next cycle, mem_req never asserted.
//  5. TIMEOUT=4, ready held 0 -> err_timeout after 4 BUS cycles.
//     - With MAU_RETRY_EN: after 4+1+4 cycles.
//  6. Reset low during BUS -> mem_req/busy 0 immediately, FSM IDLE; new req after release works.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: MIO bus between the load/store engine (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_req;
    logic                  mem_w;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_req, mem_w, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_w, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine between the CPU datapath and the MIO bus.
// Handles the mem_ready wait-state handshake, byte/half/word(/dword) lane
// steering, sign/zero extension of loads, alignment checking and a bus timeout.
// Optional feature macro: MAU_RETRY_EN -- after the first timeout the bus strobe
// drops for one cycle and the access is attempted once more before erroring.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err_align,
    output logic              err_timeout,
    mem_access_unit_if.master bus
);
    localparam int LANES = DATA_W / 8;
    localparam int LW    = $clog2(LANES);
    localparam int TW    = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BUS   = 3'd1,
        S_DONE  = 3'd2,
`ifdef MAU_RETRY_EN
        S_ERR   = 3'd3,
        S_RETRY = 3'd4
`else
        S_ERR   = 3'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              kind_q, kind_d;      // 1 = timeout, 0 = alignment
`ifdef MAU_RETRY_EN
    logic              retried_q, retried_d;
`endif
    logic              accept;
    logic              capture;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [LW-1:0]     lane;
    logic              bus_act;

    // Natural alignment: the low address bits below the access size must be zero.
    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = |a[1:0];
            default: misaligned = (DATA_W == 32) ? 1'b1 : |a[2:0];
        endcase
    endfunction

    // Byte-enable pattern of an access before it is shifted into its lane.
    function automatic logic [LANES-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = LANES'(1);
            2'b01:   size_mask = LANES'(3);
            2'b10:   size_mask = LANES'(15);
            default: size_mask = '1;
        endcase
    endfunction

    // Keep the low bytes of a right-justified load and extend to full width.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] sh,
                                                      input logic [1:0] sz,
                                                      input logic sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = sh[7:0];
        h = sh[15:0];
        w = sh[31:0];
        case (sz)
            2'b00: begin
                if (sx) load_extend = DATA_W'(b);
                else    load_extend = DATA_W'(sh[7:0]);
            end
            2'b01: begin
                if (sx) load_extend = DATA_W'(h);
                else    load_extend = DATA_W'(sh[15:0]);
            end
            2'b10: begin
                if (sx) load_extend = DATA_W'(w);
                else    load_extend = DATA_W'(sh[31:0]);
            end
            default: load_extend = sh;
        endcase
    endfunction

    assign lane    = addr_q[LW-1:0];
    assign bus_act = (state_q == S_BUS);

    // Bus signals are only live during a bus attempt; everything else idles at zero.
    assign bus.mem_req   = bus_act;
    assign bus.mem_w     = bus_act & we_q;
    assign bus.mem_addr  = bus_act ? {addr_q[ADDR_W-1:LW], {LW{1'b0}}} : '0;
    assign bus.mem_be    = bus_act ? (size_mask(size_q) << lane) : '0;
    assign bus.mem_wdata = bus_act ? (wdata_q << {lane, 3'b000}) : '0;

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err_align   = (state_q == S_ERR) & ~kind_q;
    assign err_timeout = (state_q == S_ERR) & kind_q;
    assign rdata       = rdata_q;

    // Next-state logic: accept in IDLE, wait for mem_ready in BUS, pulse in DONE/ERR.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
`ifdef MAU_RETRY_EN
        retried_d = retried_q;
`endif
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    cnt_d  = '0;
`ifdef MAU_RETRY_EN
                    retried_d = 1'b0;
`endif
                    if (misaligned(size, addr[2:0])) begin
                        state_d = S_ERR;
                        kind_d  = 1'b0;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // mem_ready is tested first so it beats a timeout on the same edge.
                if (bus.mem_ready) begin
                    capture = ~we_q;
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    cnt_d = '0;
`ifdef MAU_RETRY_EN
                    if (!retried_q) begin
                        retried_d = 1'b1;
                        state_d   = S_RETRY;
                    end else begin
                        state_d = S_ERR;
                        kind_d  = 1'b1;
                    end
`else
                    state_d = S_ERR;
                    kind_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
`ifdef MAU_RETRY_EN
            S_RETRY: state_d = S_BUS;
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= 1'b0;
`ifdef MAU_RETRY_EN
            retried_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
`ifdef MAU_RETRY_EN
            retried_q <= retried_d;
`endif
        end
    end

    // Request fields are latched at acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Load result register; holds its value until the next load completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= load_extend(bus.mem_rdata >> {lane, 3'b000}, size_q, sext_q);
        end
    end
endmodule
